// File: rtl/instr_encoder.sv
// instr_encoder: encodes decoded instruction fields into 32-bit words and writes them to
// consecutive instruction-memory addresses. Optional checksum output: INSTR_ENC_CHECKSUM_EN.
`default_nettype none

module instr_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        kind,
    input  logic [3:0]        alu_cmd,
    input  logic [4:0]        dest,
    input  logic [4:0]        src1,
    input  logic [4:0]        src2,
    input  logic [15:0]       imm,
    output logic              im_wr_en,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              enc_err,
    output logic [7:0]        err_cnt,
    output logic [ADDR_W:0]   loaded_cnt,
`ifdef INSTR_ENC_CHECKSUM_EN
    output logic [31:0]       checksum,
`endif
    output logic              full
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] im_addr_q;
    logic [ADDR_W:0]   loaded_q;
    logic [31:0]       wdata_q;
    logic              wr_en_q;
    logic              enc_err_q;
    logic [7:0]        err_q;
    logic              full_q;

    logic              accept;
    logic              legal;
    logic              wr;
    logic [5:0]        opcode;
    logic [31:0]       word;

    // Field encoding and legality check
    always_comb begin
        legal  = 1'b1;
        opcode = 6'd0;
        case (kind)
            3'd0: begin
                if (alu_cmd > 4'd9)       legal  = 1'b0;
                else if (alu_cmd == 4'd0) opcode = 6'd1;
                else if (alu_cmd == 4'd1) opcode = 6'd3;
                else                      opcode = {2'b00, alu_cmd} + 6'd3;
            end
            3'd1: begin
                if (alu_cmd > 4'd1) legal  = 1'b0;
                else                opcode = (alu_cmd == 4'd0) ? 6'd32 : 6'd33;
            end
            3'd2:    opcode = 6'd36;
            3'd3:    opcode = 6'd37;
            3'd4:    opcode = 6'd40;
            3'd5:    opcode = 6'd41;
            3'd6:    opcode = 6'd42;
            default: legal  = 1'b0;
        endcase
    end

    assign word   = {opcode, dest, src1, (kind == 3'd0) ? {src2, 11'd0} : imm};
    assign accept = in_valid & in_ready;
    assign wr     = accept & legal;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; start outranks stop
    always_comb begin
        state_d = state_q;
        if (start)
            state_d = S_LOAD;
        else if (stop && state_q != S_IDLE)
            state_d = S_IDLE;
        else if (wr && addr_q == {ADDR_W{1'b1}})
            state_d = S_FULL;
    end

    // FSM outputs
    always_comb begin
        in_ready = (state_q == S_LOAD) & ~start & ~stop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            im_addr_q <= '0;
            loaded_q  <= '0;
            wdata_q   <= '0;
            wr_en_q   <= 1'b0;
            enc_err_q <= 1'b0;
            err_q     <= 8'd0;
            full_q    <= 1'b0;
        end else begin
            wr_en_q   <= wr;
            enc_err_q <= accept & ~legal;
            if (start) begin
                addr_q   <= '0;
                loaded_q <= '0;
                full_q   <= 1'b0;
            end else if (wr) begin
                im_addr_q <= addr_q;
                wdata_q   <= word;
                addr_q    <= addr_q + 1'b1;
                loaded_q  <= loaded_q + 1'b1;
                if (addr_q == {ADDR_W{1'b1}}) full_q <= 1'b1;
            end
            if (accept && !legal && err_q != 8'hFF)
                err_q <= err_q + 8'd1;
        end
    end

`ifdef INSTR_ENC_CHECKSUM_EN
    logic [31:0] cks_q;

    // Accumulated with the word so the total is visible alongside its write strobe
    always_ff @(posedge clk) begin
        if (rst)        cks_q <= 32'd0;
        else if (start) cks_q <= 32'd0;
        else if (wr)    cks_q <= cks_q ^ word;
    end

    assign checksum = cks_q;
`endif

    assign im_wr_en   = wr_en_q;
    assign im_addr    = im_addr_q;
    assign im_wdata   = wdata_q;
    assign enc_err    = enc_err_q;
    assign err_cnt    = err_q;
    assign loaded_cnt = loaded_q;
    assign full       = full_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: encoding table, back-to-back, illegal, full, stop, reset, saturation.
`default_nettype none

module tb_instr_encoder;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst, start, stop, in_valid, in_ready;
    logic [2:0]    kind;
    logic [3:0]    alu_cmd;
    logic [4:0]    dest, src1, src2;
    logic [15:0]   imm;
    logic          im_wr_en, enc_err, full;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic [7:0]    err_cnt;
    logic [AW:0]   loaded_cnt;
`ifdef INSTR_ENC_CHECKSUM_EN
    logic [31:0]   checksum;
`endif

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .in_valid(in_valid), .in_ready(in_ready),
        .kind(kind), .alu_cmd(alu_cmd), .dest(dest), .src1(src1), .src2(src2), .imm(imm),
        .im_wr_en(im_wr_en), .im_addr(im_addr), .im_wdata(im_wdata),
        .enc_err(enc_err), .err_cnt(err_cnt), .loaded_cnt(loaded_cnt),
`ifdef INSTR_ENC_CHECKSUM_EN
        .checksum(checksum),
`endif
        .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  kind;
        logic [3:0]  cmd;
        logic [4:0]  dest;
        logic [4:0]  src1;
        logic [4:0]  src2;
        logic [15:0] imm;
        bit          legal;
        logic [31:0] word;
    } vec_t;

    vec_t vecs[15];
    int   n_pass = 0;
    int   n_total = 0;
    int   exp_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        kind     = v.kind;
        alu_cmd  = v.cmd;
        dest     = v.dest;
        src1     = v.src1;
        src2     = v.src2;
        imm      = v.imm;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // One accept, then check the registered write one cycle later
    task automatic send_chk(input vec_t v, input int exp_addr, input int exp_loaded, input string tag);
        drive(v);
        step();
        in_valid = 1'b0;
        chk({tag, "_wr_en"}, 32'(im_wr_en), 32'd1);
        chk({tag, "_addr"},  32'(im_addr),  32'(exp_addr));
        chk({tag, "_wdata"}, im_wdata,      v.word);
        chk({tag, "_loaded"}, 32'(loaded_cnt), 32'(exp_loaded));
    endtask

    initial begin
        vecs[0]  = '{3'd0, 4'd2,  5'd3,  5'd1,  5'd2,  16'h0000, 1'b1, 32'h14611000};
        vecs[1]  = '{3'd0, 4'd0,  5'd1,  5'd2,  5'd31, 16'hFFFF, 1'b1, 32'h0422F800};
        vecs[2]  = '{3'd0, 4'd1,  5'd0,  5'd0,  5'd0,  16'h0000, 1'b1, 32'h0C000000};
        vecs[3]  = '{3'd0, 4'd9,  5'd0,  5'd0,  5'd0,  16'h0000, 1'b1, 32'h30000000};
        vecs[4]  = '{3'd1, 4'd0,  5'd31, 5'd31, 5'd7,  16'hABCD, 1'b1, 32'h83FFABCD};
        vecs[5]  = '{3'd1, 4'd1,  5'd4,  5'd0,  5'd0,  16'h00FF, 1'b1, 32'h848000FF};
        vecs[6]  = '{3'd2, 4'd7,  5'd5,  5'd6,  5'd0,  16'h1234, 1'b1, 32'h90A61234};
        vecs[7]  = '{3'd3, 4'd0,  5'd0,  5'd0,  5'd0,  16'h0010, 1'b1, 32'h94000010};
        vecs[8]  = '{3'd4, 4'd0,  5'd0,  5'd2,  5'd0,  16'hFFFE, 1'b1, 32'hA002FFFE};
        vecs[9]  = '{3'd5, 4'd0,  5'd1,  5'd3,  5'd0,  16'h0008, 1'b1, 32'hA4230008};
        vecs[10] = '{3'd6, 4'd0,  5'd0,  5'd0,  5'd0,  16'h0100, 1'b1, 32'hA8000100};
        vecs[11] = '{3'd7, 4'd0,  5'd0,  5'd0,  5'd0,  16'h0000, 1'b0, 32'h00000000};
        vecs[12] = '{3'd0, 4'd10, 5'd0,  5'd0,  5'd0,  16'h0000, 1'b0, 32'h00000000};
        vecs[13] = '{3'd0, 4'd15, 5'd0,  5'd0,  5'd0,  16'h0000, 1'b0, 32'h00000000};
        vecs[14] = '{3'd1, 4'd2,  5'd0,  5'd0,  5'd0,  16'h0000, 1'b0, 32'h00000000};

        rst = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
        kind = '0; alu_cmd = '0; dest = '0; src1 = '0; src2 = '0; imm = '0;
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready),   32'd0);
        chk("rst_wr_en",    32'(im_wr_en),   32'd0);
        chk("rst_addr",     32'(im_addr),    32'd0);
        chk("rst_wdata",    im_wdata,        32'd0);
        chk("rst_enc_err",  32'(enc_err),    32'd0);
        chk("rst_err_cnt",  32'(err_cnt),    32'd0);
        chk("rst_loaded",   32'(loaded_cnt), 32'd0);
        chk("rst_full",     32'(full),       32'd0);

        // Encoding table: each vector after a fresh start, so legal words land at 0
        for (int i = 0; i < 15; i++) begin
            pulse_start();
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
            step();
            in_valid = 1'b0;
            if (!vecs[i].legal) exp_err++;
            chk($sformatf("v%0d_wr_en", i),   32'(im_wr_en), 32'(vecs[i].legal));
            chk($sformatf("v%0d_enc_err", i), 32'(enc_err),  32'(!vecs[i].legal));
            chk($sformatf("v%0d_err_cnt", i), 32'(err_cnt),  32'(exp_err));
            chk($sformatf("v%0d_loaded", i),  32'(loaded_cnt), 32'(vecs[i].legal));
            if (vecs[i].legal) begin
                chk($sformatf("v%0d_addr", i),  32'(im_addr), 32'd0);
                chk($sformatf("v%0d_wdata", i), im_wdata,     vecs[i].word);
            end
            step();
            chk($sformatf("v%0d_wr_en_1cyc", i),   32'(im_wr_en), 32'd0);
            chk($sformatf("v%0d_enc_err_1cyc", i), 32'(enc_err),  32'd0);
        end

        // Back-to-back accepts
        pulse_start();
        drive(vecs[5]);
        step();
        drive(vecs[7]);
        chk("b2b_wr0",    32'(im_wr_en), 32'd1);
        chk("b2b_addr0",  32'(im_addr),  32'd0);
        chk("b2b_wdata0", im_wdata,      32'h848000FF);
        step();
        in_valid = 1'b0;
        chk("b2b_wr1",    32'(im_wr_en),   32'd1);
        chk("b2b_addr1",  32'(im_addr),    32'd1);
        chk("b2b_wdata1", im_wdata,        32'h94000010);
        chk("b2b_loaded", 32'(loaded_cnt), 32'd2);
        step();
        chk("b2b_hold_wdata", im_wdata, 32'h94000010);

        // Illegal mid-stream leaves the address alone
        drive(vecs[13]);
        step();
        in_valid = 1'b0;
        exp_err++;
        chk("ill_wr_en",   32'(im_wr_en), 32'd0);
        chk("ill_enc_err", 32'(enc_err),  32'd1);
        chk("ill_err_cnt", 32'(err_cnt),  32'(exp_err));
        send_chk(vecs[10], 2, 3, "post_ill");

        // Last address fills memory; held in_valid is then ignored
        drive(vecs[6]);
        step();
        chk("full_wr_en",    32'(im_wr_en),   32'd1);
        chk("full_addr",     32'(im_addr),    32'd3);
        chk("full_flag",     32'(full),       32'd1);
        chk("full_in_ready", 32'(in_ready),   32'd0);
        chk("full_loaded",   32'(loaded_cnt), 32'd4);
        step();
        chk("full_nowr1", 32'(im_wr_en), 32'd0);
        step();
        chk("full_nowr2", 32'(im_wr_en), 32'd0);
        in_valid = 1'b0;
        pulse_start();
        chk("restart_full", 32'(full), 32'd0);
        chk("restart_loaded", 32'(loaded_cnt), 32'd0);
        send_chk(vecs[0], 0, 1, "restart");

        // stop with in_valid high: pending write still appears, nothing after
        pulse_start();
        drive(vecs[8]);
        step();
        stop = 1'b1;
        #1;
        chk("stop_in_ready", 32'(in_ready), 32'd0);
        chk("stop_pend_wr",  32'(im_wr_en), 32'd1);
        chk("stop_pend_wd",  im_wdata,      32'hA002FFFE);
        step();
        stop = 1'b0;
        chk("stop_nowr",   32'(im_wr_en),   32'd0);
        chk("stop_loaded", 32'(loaded_cnt), 32'd1);
        step();
        chk("idle_in_ready", 32'(in_ready), 32'd0);
        chk("idle_nowr",     32'(im_wr_en), 32'd0);
        chk("idle_loaded",   32'(loaded_cnt), 32'd1);
        in_valid = 1'b0;

`ifdef INSTR_ENC_CHECKSUM_EN
        pulse_start();
        chk("cks_clear", checksum, 32'd0);
        send_chk(vecs[0], 0, 1, "cks_w0");
        chk("cks_0", checksum, 32'h14611000);
        send_chk(vecs[5], 1, 2, "cks_w1");
        chk("cks_1", checksum, 32'h90E110FF);
`endif

        // Reset during an accept discards it
        pulse_start();
        drive(vecs[1]);
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        exp_err = 0;
        chk("rstmid_wr_en",    32'(im_wr_en),   32'd0);
        chk("rstmid_loaded",   32'(loaded_cnt), 32'd0);
        chk("rstmid_err_cnt",  32'(err_cnt),    32'd0);
        chk("rstmid_in_ready", 32'(in_ready),   32'd0);
        step();
        chk("rstmid_nowr", 32'(im_wr_en), 32'd0);

        // err_cnt saturation
        pulse_start();
        drive(vecs[11]);
        for (int i = 0; i < 300; i++) begin
            step();
            if (exp_err < 255) exp_err++;
        end
        in_valid = 1'b0;
        chk("sat_err_cnt", 32'(err_cnt), 32'(exp_err));
        chk("sat_255",     32'(err_cnt), 32'd255);
        chk("sat_nowr",    32'(im_wr_en), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
